// File: rtl/hilihase_event_hub.sv
// Signal-change capture hub: samples NUM_CH channels, queues timestamped change events
// (plus a timestamp-wrap marker) in a show-ahead FIFO, and holds a host drive register.
module hilihase_event_hub #(
  parameter  int NUM_CH     = 5,
  parameter  int CH_W       = 1,
  parameter  int TS_W       = 32,
  parameter  int FIFO_DEPTH = 16,
  localparam int ID_W       = $clog2(NUM_CH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*CH_W-1:0] sample_i,
  input  logic [NUM_CH-1:0]      ch_en,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [ID_W-1:0]        ev_id,
  output logic [CH_W-1:0]        ev_data,
  output logic [TS_W-1:0]        ev_time,
  output logic [TS_W-1:0]        ts_o,
  input  logic                   drv_wr,
  input  logic [ID_W-1:0]        drv_id,
  input  logic [CH_W-1:0]        drv_data,
  output logic [NUM_CH*CH_W-1:0] drv_o,
  input  logic                   clr_status,
  output logic                   st_lost,
  output logic                   st_bad_id
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {SNAP, RUN} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [CH_W-1:0] data;
    logic [TS_W-1:0] stamp;
  } event_t;

  state_t                  state;
  logic [NUM_CH*CH_W-1:0]  prev;
  logic [NUM_CH-1:0]       pending;
  logic [CH_W-1:0]         pend_data [NUM_CH];
  logic [TS_W-1:0]         pend_time [NUM_CH];
  logic                    wrap_pend;

  logic [CH_W-1:0]         smp [NUM_CH];
  logic [NUM_CH-1:0]       changed;
  logic [NUM_CH-1:0]       push_ch;
  logic                    push_wrap;
  logic                    push_any;
  event_t                  push_ev;
  logic                    ts_wrap;
  logic                    lost_set;
  logic                    bad_set;

  event_t                  mem [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr;
  logic [PTR_W:0]          rd_ptr;
  logic                    full;
  logic                    pop;
  logic                    can_push;
  event_t                  head;

  assign ts_wrap  = &ts_o;
  assign ev_valid = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop      = ev_valid && ev_ready;
  assign can_push = !full || pop;
  assign bad_set  = drv_wr && (drv_id >= ID_W'(NUM_CH));

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    changed = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      smp[i]     = sample_i[i*CH_W +: CH_W];
      changed[i] = ch_en[i] && (smp[i] != prev[i*CH_W +: CH_W]);
    end
  end

  // Wrap marker wins; otherwise the lowest enabled pending channel is pushed.
  always_comb begin
    push_wrap = 1'b0;
    push_ch   = '0;
    push_any  = 1'b0;
    push_ev   = '0;
    if (can_push && wrap_pend) begin
      push_wrap  = 1'b1;
      push_any   = 1'b1;
      push_ev.id = ID_W'(NUM_CH);
    end else if (can_push) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!push_any && pending[i] && ch_en[i]) begin
          push_any      = 1'b1;
          push_ch[i]    = 1'b1;
          push_ev.id    = ID_W'(i);
          push_ev.data  = pend_data[i];
          push_ev.stamp = pend_time[i];
        end
      end
    end
  end

  always_comb begin
    lost_set = (ts_wrap && wrap_pend && !push_wrap) ||
               ((state == RUN) && |(changed & pending & ~push_ch));
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SNAP;
      ts_o      <= '0;
      prev      <= '0;
      pending   <= '0;
      wrap_pend <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_data[i] <= '0;
        pend_time[i] <= '0;
      end
    end else begin
      ts_o      <= ts_o + 1'b1;
      prev      <= sample_i;
      wrap_pend <= (wrap_pend && !push_wrap) || ts_wrap;
      case (state)
        SNAP: begin
          for (int i = 0; i < NUM_CH; i++) begin
            pending[i]   <= ch_en[i];
            pend_data[i] <= smp[i];
            pend_time[i] <= ts_o;
          end
          state <= RUN;
        end
        RUN: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (changed[i]) begin
              pending[i]   <= 1'b1;
              pend_data[i] <= smp[i];
              // An overwritten slot keeps the time of its first change.
              if (!pending[i] || push_ch[i]) pend_time[i] <= ts_o;
            end else if (push_ch[i] || !ch_en[i]) begin
              pending[i] <= 1'b0;
            end
          end
        end
        default: state <= SNAP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_any) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the head is masked by ev_valid so stale entries never leak.
  always_ff @(posedge clk) begin
    if (push_any) mem[wr_ptr[PTR_W-1:0]] <= push_ev;
  end

  assign head    = mem[rd_ptr[PTR_W-1:0]];
  assign ev_id   = ev_valid ? head.id    : '0;
  assign ev_data = ev_valid ? head.data  : '0;
  assign ev_time = ev_valid ? head.stamp : '0;

  // A set condition in the same cycle overrides clr_status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_o     <= '0;
      st_lost   <= 1'b0;
      st_bad_id <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (drv_wr && (drv_id == ID_W'(i))) drv_o[i*CH_W +: CH_W] <= drv_data;
      end
      st_lost   <= lost_set || (st_lost   && !clr_status);
      st_bad_id <= bad_set  || (st_bad_id && !clr_status);
    end
  end

endmodule

// File: tb/tb_hilihase_event_hub.sv
// Directed bench: SNAP, change latency, arbitration, overwrite/backpressure, drive path,
// async reset and timestamp wrap, on two parameterisations of the hub.
module tb_hilihase_event_hub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_b;
  int          total = 0;
  int          bad   = 0;
  int          tsa   = 0;

  // Instance A: FIFO_DEPTH=2, TS_W=32.
  logic [4:0]  sample_a, ch_en_a, drv_o_a;
  logic        ev_valid_a, ev_ready_a, ev_data_a;
  logic [2:0]  ev_id_a;
  logic [31:0] ev_time_a, ts_a;
  logic        drv_wr, drv_data, clr_status, st_lost_a, st_bad_a;
  logic [2:0]  drv_id;

  // Instance B: TS_W=4, FIFO_DEPTH=4, used for the wrap marker.
  logic [4:0]  sample_b, ch_en_b, drv_o_b;
  logic        ev_valid_b, ev_ready_b, ev_data_b;
  logic [2:0]  ev_id_b, drv_id_b;
  logic [3:0]  ev_time_b, ts_b;
  logic        drv_wr_b, drv_data_b, clr_b, st_lost_b, st_bad_b;

  hilihase_event_hub #(.NUM_CH(5), .CH_W(1), .TS_W(32), .FIFO_DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .sample_i(sample_a), .ch_en(ch_en_a),
    .ev_valid(ev_valid_a), .ev_ready(ev_ready_a), .ev_id(ev_id_a),
    .ev_data(ev_data_a), .ev_time(ev_time_a), .ts_o(ts_a),
    .drv_wr(drv_wr), .drv_id(drv_id), .drv_data(drv_data), .drv_o(drv_o_a),
    .clr_status(clr_status), .st_lost(st_lost_a), .st_bad_id(st_bad_a)
  );

  hilihase_event_hub #(.NUM_CH(5), .CH_W(1), .TS_W(4), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst_b), .sample_i(sample_b), .ch_en(ch_en_b),
    .ev_valid(ev_valid_b), .ev_ready(ev_ready_b), .ev_id(ev_id_b),
    .ev_data(ev_data_b), .ev_time(ev_time_b), .ts_o(ts_b),
    .drv_wr(drv_wr_b), .drv_id(drv_id_b), .drv_data(drv_data_b), .drv_o(drv_o_b),
    .clr_status(clr_b), .st_lost(st_lost_b), .st_bad_id(st_bad_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tsa++;
  endtask

  task automatic expect_head(input string tag, input int id, input int data, input int stamp);
    check({tag, "_valid"}, 64'(ev_valid_a), 64'd1);
    check({tag, "_id"},    64'(ev_id_a),    64'(id));
    check({tag, "_data"},  64'(ev_data_a),  64'(data));
    check({tag, "_time"},  64'(ev_time_a),  64'(stamp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] snap_bits;
    int         t_chg, t14, t2, t_rst;
    int         resnap_ids [4] = '{0, 2, 3, 4};

    rst = 1'b1; rst_b = 1'b1;
    sample_a = 5'b10110; ch_en_a = 5'b11111; ev_ready_a = 1'b1;
    drv_wr = 1'b0; drv_id = '0; drv_data = 1'b0; clr_status = 1'b0;
    sample_b = '0; ch_en_b = '0; ev_ready_b = 1'b0;
    drv_wr_b = 1'b0; drv_id_b = '0; drv_data_b = 1'b0; clr_b = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(ev_valid_a), 64'd0);
    check("rst_ts",    64'(ts_a),       64'd0);
    check("rst_drv",   64'(drv_o_a),    64'd0);
    check("rst_lost",  64'(st_lost_a),  64'd0);
    check("rst_bad",   64'(st_bad_a),   64'd0);
    check("rst_id",    64'(ev_id_a),    64'd0);

    // SNAP: five events, ids 0..4, time 0.
    rst = 1'b0; tsa = 0;
    snap_bits = 5'b10110;
    step();
    check("snap_latency", 64'(ev_valid_a), 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      expect_head("snap", k, int'(snap_bits[k]), 0);
    end
    step();
    check("snap_drained", 64'(ev_valid_a), 64'd0);
    repeat (3) step();
    check("idle_stable", 64'(ev_valid_a), 64'd0);
    check("ts_count",    64'(ts_a),       64'(tsa));

    // Single change: two-cycle latency, head holds under backpressure.
    ev_ready_a = 1'b0;
    sample_a[3] = 1'b1; t_chg = tsa;
    step();
    check("chg_latency", 64'(ev_valid_a), 64'd0);
    step();
    expect_head("chg", 3, 1, t_chg);
    repeat (3) step();
    expect_head("chg_hold", 3, 1, t_chg);
    ev_ready_a = 1'b1;
    step();
    check("chg_popped", 64'(ev_valid_a), 64'd0);
    ev_ready_a = 1'b0;

    // Channels 1 and 4 together, then ch2 overwritten while the FIFO is full.
    sample_a = 5'b01100; t14 = tsa;
    step();
    step();
    expect_head("pair1", 1, 0, t14);
    step();
    sample_a[2] = 1'b0; t2 = tsa;
    step();
    sample_a[2] = 1'b1;
    step();
    check("lost_set", 64'(st_lost_a), 64'd1);
    expect_head("full_hold", 1, 0, t14);
    ev_ready_a = 1'b1;
    step();
    expect_head("pair4", 4, 0, t14);
    step();
    expect_head("lost2", 2, 1, t2);
    step();
    check("lost_drained", 64'(ev_valid_a), 64'd0);
    ev_ready_a = 1'b0;
    check("lost_sticky", 64'(st_lost_a), 64'd1);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    check("lost_clear", 64'(st_lost_a), 64'd0);

    // Drive path.
    drv_wr = 1'b1; drv_id = 3'd2; drv_data = 1'b1;
    step();
    drv_wr = 1'b0;
    check("drv_ch2",   64'(drv_o_a),    64'b00100);
    check("drv_no_ev", 64'(ev_valid_a), 64'd0);
    check("drv_ok",    64'(st_bad_a),   64'd0);
    repeat (2) step();
    check("drv_no_ev2", 64'(ev_valid_a), 64'd0);
    drv_wr = 1'b1; drv_id = 3'd7; drv_data = 1'b1;
    step();
    drv_wr = 1'b0;
    check("bad7_drv", 64'(drv_o_a),  64'b00100);
    check("bad7_set", 64'(st_bad_a), 64'd1);
    drv_wr = 1'b1; drv_id = 3'd5; clr_status = 1'b1;
    step();
    drv_wr = 1'b0;
    check("bad5_wins", 64'(st_bad_a), 64'd1);
    check("bad5_drv",  64'(drv_o_a),  64'b00100);
    step();
    clr_status = 1'b0;
    check("bad_clear", 64'(st_bad_a), 64'd0);
    drv_wr = 1'b1; drv_id = 3'd4; drv_data = 1'b1;
    step();
    drv_wr = 1'b0;
    check("drv_ch4", 64'(drv_o_a), 64'b10100);

    // Asynchronous reset with events queued, then SNAP with ch1 disabled.
    sample_a = 5'b11111; t_rst = tsa;
    repeat (3) step();
    expect_head("pre_rst", 0, 1, t_rst);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(ev_valid_a), 64'd0);
    check("arst_drv",   64'(drv_o_a),    64'd0);
    check("arst_ts",    64'(ts_a),       64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; tsa = 0;
    ch_en_a = 5'b11101; ev_ready_a = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      expect_head("resnap", resnap_ids[k], 1, 0);
    end
    step();
    check("resnap_done", 64'(ev_valid_a), 64'd0);

    // Timestamp wrap marker on the narrow-timestamp instance.
    check("b_rst_valid", 64'(ev_valid_b), 64'd0);
    check("b_rst_ts",    64'(ts_b),       64'd0);
    rst_b = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("wrap_ts",      64'(ts_b),       64'd0);
    check("wrap_latency", 64'(ev_valid_b), 64'd0);
    @(posedge clk);
    #1;
    check("wrap_valid", 64'(ev_valid_b), 64'd1);
    check("wrap_id",    64'(ev_id_b),    64'd5);
    check("wrap_data",  64'(ev_data_b),  64'd0);
    check("wrap_time",  64'(ev_time_b),  64'd0);
    check("wrap_lost",  64'(st_lost_b),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
